// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - six-digit multiplexed seven-segment scan driver
// Frame-snapshotted digits with blank interval, leading-zero suppression and blink.
module seg7_scan_driver #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_points_2,
    input  logic [6:0] seg_points_1,
    input  logic [6:0] seg_points_0,
    input  logic [6:0] seg_timer_1,
    input  logic [6:0] seg_timer_0,
    input  logic [6:0] seg_level,
    input  logic       done,
    input  logic       zero_blank_en,
    output logic [6:0] seg_out,
    output logic [5:0] dig_en,
    output logic       frame_tick
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] CYC_LAST       = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CYC_BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [FW-1:0] FRAME_LAST     = FW'(BLINK_FRAMES - 1);
    localparam logic [6:0]    ZERO_PAT       = 7'b0111111;

    typedef enum logic {
        ST_BLANK,
        ST_DRIVE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cyc_q, cyc_d;
    logic [2:0]      slot_q, slot_d;
    logic [FW-1:0]   frame_q, frame_d;
    logic            phase_q, phase_d;
    logic [5:0][6:0] pat_q, pat_d;
    logic            done_sh_q, done_sh_d;
    logic            zbe_sh_q, zbe_sh_d;
    logic [6:0]      seg_out_q, seg_out_d;
    logic [5:0]      dig_en_q, dig_en_d;

    logic            frame_start;
    logic            cyc_wrap;
    logic            suppress;
    logic [6:0]      seg_sel;

    always_comb begin
        frame_start = (slot_q == 3'd0) && (cyc_q == '0);
        cyc_wrap    = (cyc_q == CYC_LAST);

        cyc_d     = cyc_wrap ? '0 : cyc_q + CW'(1);
        slot_d    = slot_q;
        state_d   = state_q;
        frame_d   = frame_q;
        phase_d   = phase_q;
        pat_d     = pat_q;
        done_sh_d = done_sh_q;
        zbe_sh_d  = zbe_sh_q;

        if (cyc_wrap) begin
            slot_d = (slot_q == 3'd5) ? 3'd0 : slot_q + 3'd1;
        end

        case (state_q)
            ST_BLANK: if (cyc_q == CYC_BLANK_LAST) state_d = ST_DRIVE;
            ST_DRIVE: if (cyc_wrap) state_d = ST_BLANK;
            default:  state_d = ST_BLANK;
        endcase

        // Blink bookkeeping uses the done flag captured at the previous frame start.
        if (frame_start) begin
            pat_d     = {seg_level, seg_timer_0, seg_timer_1,
                         seg_points_0, seg_points_1, seg_points_2};
            done_sh_d = done;
            zbe_sh_d  = zero_blank_en;
            if (!done_sh_q) begin
                frame_d = '0;
                phase_d = 1'b0;
            end else if (frame_q == FRAME_LAST) begin
                frame_d = '0;
                phase_d = ~phase_q;
            end else begin
                frame_d = frame_q + FW'(1);
            end
        end

        suppress = 1'b0;
        seg_sel  = 7'd0;
        case (slot_q)
            3'd0: begin
                seg_sel  = pat_q[0];
                suppress = zbe_sh_q && (pat_q[0] == ZERO_PAT);
            end
            3'd1: begin
                seg_sel  = pat_q[1];
                suppress = zbe_sh_q && (pat_q[0] == ZERO_PAT) && (pat_q[1] == ZERO_PAT);
            end
            3'd2: seg_sel = pat_q[2];
            3'd3: begin
                seg_sel  = pat_q[3];
                suppress = zbe_sh_q && (pat_q[3] == ZERO_PAT);
            end
            3'd4: seg_sel = pat_q[4];
            3'd5: seg_sel = pat_q[5];
            default: seg_sel = 7'd0;
        endcase

        seg_out_d = 7'd0;
        dig_en_d  = 6'd0;
        if ((state_q == ST_DRIVE) && !suppress && !phase_q) begin
            seg_out_d = seg_sel;
            dig_en_d  = 6'b000001 << slot_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_BLANK;
            cyc_q     <= '0;
            slot_q    <= 3'd0;
            frame_q   <= '0;
            phase_q   <= 1'b0;
            pat_q     <= '0;
            done_sh_q <= 1'b0;
            zbe_sh_q  <= 1'b0;
            seg_out_q <= 7'd0;
            dig_en_q  <= 6'd0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            slot_q    <= slot_d;
            frame_q   <= frame_d;
            phase_q   <= phase_d;
            pat_q     <= pat_d;
            done_sh_q <= done_sh_d;
            zbe_sh_q  <= zbe_sh_d;
            seg_out_q <= seg_out_d;
            dig_en_q  <= dig_en_d;
        end
    end

    assign seg_out    = seg_out_q;
    assign dig_en     = dig_en_q;
    assign frame_tick = frame_start && !rst;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;
    localparam int D  = 8;
    localparam int B  = 2;
    localparam int BF = 2;
    localparam int FL = 6 * D;
    localparam logic [6:0] Z = 7'b0111111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] p2 = '0, p1 = '0, p0 = '0, t1 = '0, t0 = '0, lv = '0;
    logic       done = 1'b0, zbe = 1'b0;
    logic [6:0] seg_out;
    logic [5:0] dig_en;
    logic       frame_tick;

    always #5 clk = ~clk;

    seg7_scan_driver #(.SCAN_DIV(D), .BLANK_CYCLES(B), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst(rst),
        .seg_points_2(p2), .seg_points_1(p1), .seg_points_0(p0),
        .seg_timer_1(t1), .seg_timer_0(t0), .seg_level(lv),
        .done(done), .zero_blank_en(zbe),
        .seg_out(seg_out), .dig_en(dig_en), .frame_tick(frame_tick)
    );

    typedef struct packed {
        logic [5:0][6:0] pat;
        logic            done;
        logic            zbe;
    } snap_t;

    typedef struct packed {
        logic [41:0] pats;
        logic        zbe;
        logic        done;
        logic [5:0]  mask;
    } vec_t;

    snap_t      hist[$];
    int         t = 0;
    int         passed = 0;
    int         total = 0;
    bit         armed = 0;
    logic [5:0] prev_dig = '0;
    logic [5:0] acc = '0;
    logic [6:0] seg2_seen = '0;
    vec_t       vecs [13];

    function automatic logic [41:0] pk(input logic [6:0] a, b, c, d, e, f);
        return {f, e, d, c, b, a};
    endfunction

    function automatic logic [6:0] rpat();
        case ($urandom_range(0, 3))
            0, 1:    return Z;
            2:       return 7'($urandom);
            default: return 7'h06;
        endcase
    endfunction

    task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s t=%0d got=%h exp=%h", name, t, got, exp);
    endtask

    // Blink state of frame f from the run of consecutive done snapshots ending at f-1.
    function automatic bit dark(input int f);
        int s;
        if (f == 0 || !hist[f-1].done) return 0;
        s = f - 1;
        while (s > 0 && hist[s-1].done) s--;
        return (((f - s) / BF) % 2) == 1;
    endfunction

    task automatic expect_out(output logic [6:0] es, output logic [5:0] ed);
        int p, f, slot, cyc;
        snap_t sn;
        bit supp;
        es = '0;
        ed = '0;
        if (t == 0) return;
        p = t - 1;
        f = p / FL;
        slot = (p / D) % 6;
        cyc = p % D;
        if (cyc < B || f >= hist.size()) return;
        sn = hist[f];
        supp = sn.zbe && ((slot == 0 && sn.pat[0] == Z) ||
                          (slot == 1 && sn.pat[0] == Z && sn.pat[1] == Z) ||
                          (slot == 3 && sn.pat[3] == Z));
        if (supp || dark(f)) return;
        ed = 6'(1) << slot;
        es = sn.pat[slot];
    endtask

    task automatic tick();
        logic [6:0] es;
        logic [5:0] ed;
        #1;
        if (armed) begin
            expect_out(es, ed);
            check("seg_out", seg_out, es);
            check("dig_en", {1'b0, dig_en}, {1'b0, ed});
            check("frame_tick", {6'd0, frame_tick}, {6'd0, (!rst && (t % FL == 0))});
            check("onehot", {6'd0, ($countones(dig_en) <= 1)}, 7'd1);
            check("no_hop", {6'd0, (prev_dig != 0 && dig_en != 0 && prev_dig != dig_en)}, 7'd0);
            acc |= dig_en;
            if (dig_en[2]) seg2_seen = seg_out;
            prev_dig = dig_en;
        end
        if (!rst && (t % FL == 0)) hist.push_back({{lv, t0, t1, p0, p1, p2}, done, zbe});
        @(posedge clk);
        if (rst) begin
            t = 0;
            hist.delete();
            armed = 1;
        end else begin
            t++;
        end
        @(negedge clk);
    endtask

    task automatic align();
        while (t % FL != 0) tick();
    endtask

    initial begin
        vecs[0]  = '{pk(7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h06), 1'b0, 1'b0, 6'b111111};
        vecs[1]  = '{pk(Z, Z, Z, Z, 7'h06, 7'h06),                 1'b1, 1'b0, 6'b110100};
        vecs[2]  = '{pk(7'h06, Z, Z, Z, 7'h5B, 7'h06),             1'b1, 1'b0, 6'b110111};
        vecs[3]  = '{pk(Z, 7'h06, Z, Z, 7'h5B, 7'h06),             1'b1, 1'b0, 6'b110110};
        vecs[4]  = '{pk(Z, Z, Z, Z, Z, Z),                         1'b0, 1'b0, 6'b111111};
        for (int i = 5; i < 11; i++)
            vecs[i] = '{pk(7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h06), 1'b0, 1'b1,
                        ((i == 7 || i == 8) ? 6'b000000 : 6'b111111)};
        vecs[11] = '{pk(7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h06), 1'b0, 1'b0, 6'b000000};
        vecs[12] = '{pk(7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h06), 1'b0, 1'b0, 6'b111111};

        @(negedge clk);
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            {lv, t0, t1, p0, p1, p2} = vecs[i].pats;
            zbe  = vecs[i].zbe;
            done = vecs[i].done;
            tick();
            if (i > 0) check("vec_mask", {1'b0, acc}, {1'b0, vecs[i-1].mask});
            acc = '0;
            repeat (FL - 1) tick();
        end
        tick();
        check("vec_mask", {1'b0, acc}, {1'b0, vecs[12].mask});

        // Mid-frame change of points_0 must not show until the next frame.
        align();
        {lv, t0, t1, p0, p1, p2} = pk(7'h01, 7'h02, 7'h06, 7'h04, 7'h05, 7'h06);
        zbe = 1'b0;
        done = 1'b0;
        repeat (12) tick();
        p0 = 7'h5B;
        repeat (20) tick();
        check("tear_same_frame", seg2_seen, 7'h06);
        repeat (FL) tick();
        check("tear_next_frame", seg2_seen, 7'h5B);

        // Blink with done dropped mid-way through the first dark frame.
        align();
        done = 1'b1;
        for (int j = 0; j < 5; j++) begin
            tick();
            if (j > 0) check("blink_mask", {1'b0, acc}, {1'b0, ((j == 3 || j == 4) ? 6'd0 : 6'b111111)});
            acc = '0;
            for (int k = 1; k < FL; k++) begin
                if (j == 2 && k == 20) done = 1'b0;
                tick();
            end
        end
        tick();
        check("blink_mask", {1'b0, acc}, {1'b0, 6'b111111});

        // Reset pulse at slot 3, cycle 5.
        align();
        repeat (3 * D + 5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rst_frame_tick", {6'd0, frame_tick}, 7'd1);
        check("rst_dig_en", {1'b0, dig_en}, 7'd0);
        check("rst_seg_out", seg_out, 7'd0);
        begin
            bit found = 0;
            for (int i = 0; i < 4 * D && !found; i++) begin
                tick();
                if (dig_en != 0) begin
                    found = 1;
                    check("rst_first_digit", {1'b0, dig_en}, 7'b0000001);
                end
            end
            if (!found) check("rst_first_digit_timeout", 7'd0, 7'd1);
        end

        for (int c = 0; c < 10000; c++) begin
            if (t % FL == 0 && $urandom_range(0, 2) == 0) begin
                p2 = rpat(); p1 = rpat(); p0 = rpat();
                t1 = rpat(); t0 = rpat(); lv = rpat();
            end
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 5))
                    0: p2 = rpat();
                    1: p1 = rpat();
                    2: p0 = rpat();
                    3: t1 = rpat();
                    4: t0 = rpat();
                    default: lv = rpat();
                endcase
            end
            if ($urandom_range(0, 59) == 0) zbe = ~zbe;
            if ($urandom_range(0, 149) == 0) done = ~done;
            rst = ($urandom_range(0, 1999) == 0);
            tick();
        end
        rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
